// File: rtl/paint_pkg.sv
// Shared framebuffer geometry, pixel payload and writer FSM state encoding.
package paint_pkg;

    localparam int unsigned FB_WIDTH   = 320;
    localparam int unsigned FB_HEIGHT  = 180;
    localparam int unsigned FB_PIXELS  = FB_WIDTH * FB_HEIGHT;
    localparam int unsigned COLOR_W    = 8;
    localparam int unsigned ADDR_W     = 16;
    localparam int unsigned HCOUNT_W   = 11;
    localparam int unsigned VCOUNT_W   = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        CLEAR = 2'd2
    } fb_wr_state_t;

    typedef struct packed {
        logic [HCOUNT_W-1:0] hcount;
        logic [VCOUNT_W-1:0] vcount;
        logic [COLOR_W-1:0]  color;
    } pixel_t;

endpackage

// File: rtl/paint_fb_writer_if.sv
// Painter pixel stream in, framebuffer write port and status out.
interface paint_fb_writer_if;
    import paint_pkg::*;

    logic [HCOUNT_W-1:0] hcount_in;
    logic [VCOUNT_W-1:0] vcount_in;
    logic [COLOR_W-1:0]  color_in;
    logic                data_valid_in;
    logic                clear_in;
    logic [ADDR_W-1:0]   fb_addr_out;
    logic [COLOR_W-1:0]  fb_data_out;
    logic                fb_we_out;
    logic                ready_out;
    logic                overflow_out;

    modport master (
        output hcount_in, vcount_in, color_in, data_valid_in, clear_in,
        input  fb_addr_out, fb_data_out, fb_we_out, ready_out, overflow_out
    );

    modport slave (
        input  hcount_in, vcount_in, color_in, data_valid_in, clear_in,
        output fb_addr_out, fb_data_out, fb_we_out, ready_out, overflow_out
    );

endinterface

// File: rtl/paint_fb_writer_sync_fifo.sv
// Show-ahead synchronous FIFO; head entry is visible on rdata_c whenever not empty.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             push_in,
    input  logic [WIDTH-1:0] wdata_in,
    input  logic             pop_in,
    output logic [WIDTH-1:0] rdata_c,
    output logic             full_c,
    output logic             empty_c
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;

    // Pointer advance; the extra MSB distinguishes full from empty.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(push_in);
        rd_ptr_d = rd_ptr_q + PW'(pop_in);
    end

    // Pointer registers.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage; contents need no reset since the pointers define validity.
    always_ff @(posedge clk_in) begin
        if (push_in) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_in;
        end
    end

    assign rdata_c = mem_q[rd_ptr_q[AW-1:0]];
    assign empty_c = (wr_ptr_q == rd_ptr_q);
    assign full_c  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/paint_fb_writer.sv
// Buffers the painter pixel stream and writes in-bounds pixels to the framebuffer;
// also runs a full-screen clear sweep on request.
module paint_fb_writer
    import paint_pkg::*;
#(
    parameter int unsigned        FIFO_DEPTH  = 16,
    parameter logic [COLOR_W-1:0] CLEAR_COLOR = '0
) (
    input  logic             clk_in,
    input  logic             rst_in,
    paint_fb_writer_if.slave bus
);

    localparam logic [ADDR_W-1:0] CLEAR_LAST = ADDR_W'(FB_PIXELS - 1);

    fb_wr_state_t state_q, state_d;

    pixel_t              in_pix;
    pixel_t              head;
    logic [$bits(pixel_t)-1:0] fifo_rdata;
    logic                fifo_full, fifo_empty;
    logic                push_c, pop_c;

    logic                s1_valid_q, s1_valid_d;
    logic                s1_inrange_q, s1_inrange_d;
    logic [ADDR_W-1:0]   s1_prod_q, s1_prod_d;
    logic [HCOUNT_W-1:0] s1_hcount_q, s1_hcount_d;
    logic [COLOR_W-1:0]  s1_color_q, s1_color_d;
    logic                s2_valid_q, s2_valid_d;

    logic [ADDR_W-1:0]   fb_addr_q, fb_addr_d;
    logic [COLOR_W-1:0]  fb_data_q, fb_data_d;
    logic                fb_we_q, fb_we_d;
    logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
    logic                overflow_q, overflow_d;
    logic                live_q, live_d;

    assign in_pix = '{hcount: bus.hcount_in, vcount: bus.vcount_in, color: bus.color_in};
    assign head   = fifo_rdata;

    sync_fifo #(
        .WIDTH ($bits(pixel_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .push_in  (push_c),
        .wdata_in (in_pix),
        .pop_in   (pop_c),
        .rdata_c  (fifo_rdata),
        .full_c   (fifo_full),
        .empty_c  (fifo_empty)
    );

    // FSM state register.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: clear requests only honoured in IDLE; sweep starts once the pipeline is empty.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.clear_in) state_d = DRAIN;
            DRAIN:   if (!s1_valid_q && !s2_valid_q) state_d = CLEAR;
            CLEAR:   if (clr_cnt_q == CLEAR_LAST) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FIFO control, address pipeline and clear-sweep outputs.
    always_comb begin
        pop_c        = (state_q == IDLE) && !fifo_empty;
        push_c       = bus.data_valid_in && (!fifo_full || pop_c);
        overflow_d   = overflow_q || (bus.data_valid_in && !push_c);
        live_d       = 1'b1;

        // Range check gates the multiply so out-of-range rows cannot alias into the frame.
        s1_valid_d   = pop_c;
        s1_inrange_d = (32'(head.hcount) < FB_WIDTH) && (32'(head.vcount) < FB_HEIGHT);
        s1_prod_d    = s1_inrange_d ? ADDR_W'(32'(head.vcount) * FB_WIDTH) : '0;
        s1_hcount_d  = head.hcount;
        s1_color_d   = head.color;

        s2_valid_d   = s1_valid_q;
        fb_addr_d    = s1_prod_q + ADDR_W'(s1_hcount_q);
        fb_data_d    = s1_color_q;
        fb_we_d      = s1_valid_q && s1_inrange_q;
        clr_cnt_d    = '0;

        if (state_q == CLEAR) begin
            fb_addr_d = clr_cnt_q;
            fb_data_d = CLEAR_COLOR;
            fb_we_d   = 1'b1;
            clr_cnt_d = (clr_cnt_q == CLEAR_LAST) ? '0 : clr_cnt_q + ADDR_W'(1);
        end
    end

    // Datapath and status registers.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            s1_valid_q   <= 1'b0;
            s1_inrange_q <= 1'b0;
            s1_prod_q    <= '0;
            s1_hcount_q  <= '0;
            s1_color_q   <= '0;
            s2_valid_q   <= 1'b0;
            fb_addr_q    <= '0;
            fb_data_q    <= '0;
            fb_we_q      <= 1'b0;
            clr_cnt_q    <= '0;
            overflow_q   <= 1'b0;
            live_q       <= 1'b0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_inrange_q <= s1_inrange_d;
            s1_prod_q    <= s1_prod_d;
            s1_hcount_q  <= s1_hcount_d;
            s1_color_q   <= s1_color_d;
            s2_valid_q   <= s2_valid_d;
            fb_addr_q    <= fb_addr_d;
            fb_data_q    <= fb_data_d;
            fb_we_q      <= fb_we_d;
            clr_cnt_q    <= clr_cnt_d;
            overflow_q   <= overflow_d;
            live_q       <= live_d;
        end
    end

    assign bus.fb_addr_out  = fb_addr_q;
    assign bus.fb_data_out  = fb_data_q;
    assign bus.fb_we_out    = fb_we_q;
    assign bus.overflow_out = overflow_q;
    // Held low through reset; otherwise high only when nothing is queued, in flight or sweeping.
    assign bus.ready_out    = live_q && (state_q == IDLE) && fifo_empty &&
                              !s1_valid_q && !s2_valid_q && !fb_we_q;

endmodule

// File: tb/tb_paint_fb_writer.sv
// Directed bench for paint_fb_writer.
module tb_paint_fb_writer;
    import paint_pkg::*;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
        logic [31:0] cyc;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [31:0] cyc = '0;
    int checks = 0;
    int errors = 0;
    wr_t wq[$];

    paint_fb_writer_if bus_if ();

    paint_fb_writer dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus_if)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 32'd1;

    // Write log captured mid-cycle.
    always @(negedge clk) begin
        if (bus_if.fb_we_out === 1'b1)
            wq.push_back('{addr: bus_if.fb_addr_out, data: bus_if.fb_data_out, cyc: cyc});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_pix(input int h, input int v, input int c);
        bus_if.hcount_in     = 11'(h);
        bus_if.vcount_in     = 10'(v);
        bus_if.color_in      = 8'(c);
        bus_if.data_valid_in = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if (bus_if.fb_we_out !== 1'b0) begin errors++; $display("FAIL reset_we got %b want 0", bus_if.fb_we_out); end
        checks++;
        if (bus_if.fb_addr_out !== 16'd0) begin errors++; $display("FAIL reset_addr got %0d want 0", bus_if.fb_addr_out); end
        checks++;
        if (bus_if.fb_data_out !== 8'd0) begin errors++; $display("FAIL reset_data got %0h want 0", bus_if.fb_data_out); end
        checks++;
        if (bus_if.overflow_out !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", bus_if.overflow_out); end
        checks++;
        if (bus_if.ready_out !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", bus_if.ready_out); end
        rst = 1'b0;
        tick();
        checks++;
        if (bus_if.ready_out !== 1'b1) begin errors++; $display("FAIL post_reset_ready got %b want 1", bus_if.ready_out); end
    endtask

    task automatic test_single();
        logic [31:0] n0;
        wq.delete();
        drive_pix(10, 5, 8'h3C);
        tick();
        n0 = cyc;
        bus_if.data_valid_in = 1'b0;
        checks++;
        if (bus_if.ready_out !== 1'b0) begin errors++; $display("FAIL single_ready_busy got %b want 0", bus_if.ready_out); end
        repeat (6) tick();
        checks++;
        if (wq.size() != 1) begin
            errors++; $display("FAIL single_count got %0d want 1", wq.size());
        end else begin
            checks++;
            if (wq[0].addr !== 16'd1610) begin errors++; $display("FAIL single_addr got %0d want 1610", wq[0].addr); end
            checks++;
            if (wq[0].data !== 8'h3C) begin errors++; $display("FAIL single_data got %0h want 3c", wq[0].data); end
            checks++;
            if (wq[0].cyc !== n0 + 32'd2) begin errors++; $display("FAIL single_latency got %0d want %0d", wq[0].cyc - n0, 2); end
        end
        checks++;
        if (bus_if.ready_out !== 1'b1) begin errors++; $display("FAIL single_ready_idle got %b want 1", bus_if.ready_out); end
    endtask

    task automatic test_burst();
        int bad;
        wq.delete();
        for (int i = 0; i < 16; i++) begin
            drive_pix(i, 7, 8'h40 + i);
            tick();
        end
        bus_if.data_valid_in = 1'b0;
        repeat (8) tick();
        checks++;
        if (wq.size() != 16) begin
            errors++; $display("FAIL burst_count got %0d want 16", wq.size());
        end else begin
            bad = 0;
            for (int i = 0; i < 16; i++) begin
                if (wq[i].addr !== 16'(2240 + i)) bad++;
                if (wq[i].data !== 8'(8'h40 + i)) bad++;
                if (i > 0 && wq[i].cyc !== wq[i-1].cyc + 32'd1) bad++;
            end
            checks++;
            if (bad != 0) begin errors++; $display("FAIL burst_contents got %0d bad fields want 0", bad); end
        end
        checks++;
        if (bus_if.overflow_out !== 1'b0) begin errors++; $display("FAIL burst_overflow got %b want 0", bus_if.overflow_out); end
    endtask

    task automatic test_range();
        wq.delete();
        drive_pix(320, 0, 8'h11);
        tick();
        drive_pix(0, 180, 8'h22);
        tick();
        drive_pix(5, 2, 8'h55);
        tick();
        bus_if.data_valid_in = 1'b0;
        repeat (8) tick();
        checks++;
        if (wq.size() != 1) begin
            errors++; $display("FAIL range_count got %0d want 1", wq.size());
        end else begin
            checks++;
            if (wq[0].addr !== 16'd645) begin errors++; $display("FAIL range_addr got %0d want 645", wq[0].addr); end
            checks++;
            if (wq[0].data !== 8'h55) begin errors++; $display("FAIL range_data got %0h want 55", wq[0].data); end
        end
    endtask

    task automatic test_clear();
        int bad;
        int n;
        wq.delete();
        bus_if.clear_in = 1'b1;
        tick();
        bus_if.clear_in = 1'b0;
        drive_pix(1, 1, 8'h77);
        tick();
        bus_if.data_valid_in = 1'b0;
        repeat (57620) tick();
        checks++;
        if (wq.size() != 57601) begin errors++; $display("FAIL clear_count got %0d want 57601", wq.size()); end
        n = (wq.size() < 57600) ? wq.size() : 57600;
        bad = 57600 - n;
        for (int i = 0; i < n; i++) begin
            if (wq[i].addr !== 16'(i) || wq[i].data !== 8'h00) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL clear_sweep got %0d bad writes want 0", bad); end
        if (wq.size() == 57601) begin
            checks++;
            if (wq[57600].addr !== 16'd321 || wq[57600].data !== 8'h77) begin
                errors++; $display("FAIL clear_survivor got addr %0d data %0h want addr 321 data 77", wq[57600].addr, wq[57600].data);
            end
        end
        checks++;
        if (bus_if.ready_out !== 1'b1) begin errors++; $display("FAIL clear_ready got %b want 1", bus_if.ready_out); end
    endtask

    task automatic test_overflow_reset();
        bit hit;
        bus_if.clear_in = 1'b1;
        tick();
        for (int i = 0; i < 20; i++) begin
            drive_pix(i, 3, i);
            tick();
        end
        bus_if.data_valid_in = 1'b0;
        checks++;
        if (bus_if.overflow_out !== 1'b1) begin errors++; $display("FAIL ovf_set got %b want 1", bus_if.overflow_out); end
        repeat (5) tick();
        checks++;
        if (bus_if.overflow_out !== 1'b1 || bus_if.ready_out !== 1'b0) begin
            errors++; $display("FAIL ovf_sticky got ovf %b ready %b want ovf 1 ready 0", bus_if.overflow_out, bus_if.ready_out);
        end
        hit = 1'b0;
        for (int k = 0; k < 3000 && !hit; k++) begin
            if (bus_if.fb_we_out === 1'b1 && bus_if.fb_addr_out === 16'd1000) hit = 1'b1;
            else tick();
        end
        checks++;
        if (!hit) begin errors++; $display("FAIL sweep_addr1000_timeout got none want addr 1000"); end
        bus_if.clear_in = 1'b0;
        rst = 1'b1;
        tick();
        checks++;
        if (bus_if.fb_we_out !== 1'b0 || bus_if.overflow_out !== 1'b0) begin
            errors++; $display("FAIL rst_abort got we %b ovf %b want we 0 ovf 0", bus_if.fb_we_out, bus_if.overflow_out);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (bus_if.ready_out !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", bus_if.ready_out); end
        wq.delete();
        repeat (10) tick();
        checks++;
        if (wq.size() != 0) begin errors++; $display("FAIL rst_discard got %0d writes want 0", wq.size()); end
    endtask

    initial begin
        bus_if.hcount_in     = '0;
        bus_if.vcount_in     = '0;
        bus_if.color_in      = '0;
        bus_if.data_valid_in = 1'b0;
        bus_if.clear_in      = 1'b0;
        test_reset();
        test_single();
        test_burst();
        test_range();
        test_clear();
        test_overflow_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
